// File: rtl/microsequencer_pkg.sv
// Shared microsequencer encodings: next-state modes, condition selects,
// MIPS opcode/funct values and the microstore entry points they dispatch to.
package microsequencer_pkg;

  typedef enum logic [2:0] {
    N_ENCODE   = 3'b000,
    N_JUMP     = 3'b001,
    N_INC      = 3'b010,
    N_BR_INC   = 3'b011,
    N_BR_ENC   = 3'b100,
    N_WAIT     = 3'b101,
    N_HOLD     = 3'b110,
    N_ZERO     = 3'b111
  } n_mode_e;

  typedef enum logic [1:0] {
    COND_MOC   = 2'b00,
    COND_ZERO  = 2'b01,
    COND_MET   = 2'b10,
    COND_FALSE = 2'b11
  } cond_sel_e;

  // One microstore control word, minus the target state (its width is a parameter).
  typedef struct packed {
    n_mode_e   mode;
    logic      inv;
    cond_sel_e sel;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam int ENC_W = 8;
  localparam logic [ENC_W-1:0] ST_FETCH = 8'd0;
  localparam logic [ENC_W-1:0] ST_ADD   = 8'd6;
  localparam logic [ENC_W-1:0] ST_JR    = 8'd11;
  localparam logic [ENC_W-1:0] ST_J     = 8'd12;
  localparam logic [ENC_W-1:0] ST_ADDU  = 8'd16;
  localparam logic [ENC_W-1:0] ST_ADDI  = 8'd17;
  localparam logic [ENC_W-1:0] ST_ORI   = 8'd18;
  localparam logic [ENC_W-1:0] ST_SUB   = 8'd19;
  localparam logic [ENC_W-1:0] ST_AND   = 8'd21;
  localparam logic [ENC_W-1:0] ST_OR    = 8'd22;
  localparam logic [ENC_W-1:0] ST_SLT   = 8'd23;
  localparam logic [ENC_W-1:0] ST_LUI   = 8'd30;
  localparam logic [ENC_W-1:0] ST_LW    = 8'd31;
  localparam logic [ENC_W-1:0] ST_SW    = 8'd36;
  localparam logic [ENC_W-1:0] ST_BEQ   = 8'd37;
  localparam logic [ENC_W-1:0] ST_BNE   = 8'd38;
  localparam logic [ENC_W-1:0] ST_JAL   = 8'd44;

endpackage

// File: rtl/instr_encoder.sv
// Instruction decoder: maps the IR opcode/funct to a microstore entry state.
// Latency: purely combinational.
// Backpressure: none; the output follows ir continuously.
module instr_encoder
  import microsequencer_pkg::*;
#(
  parameter int STATE_W = 7
) (
  input  logic [31:0]        ir,
  output logic [STATE_W-1:0] enc_state
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [ENC_W-1:0] entry;
  logic             unused_ir_bits;

  assign opcode         = ir[31:26];
  assign funct          = ir[5:0];
  assign unused_ir_bits = ^ir[25:6];

  always_comb begin
    entry = ST_FETCH;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  entry = ST_ADD;
          FN_ADDU: entry = ST_ADDU;
          FN_SUB:  entry = ST_SUB;
          FN_AND:  entry = ST_AND;
          FN_OR:   entry = ST_OR;
          FN_SLT:  entry = ST_SLT;
          FN_JR:   entry = ST_JR;
          default: entry = ST_FETCH;
        endcase
      end
      OP_ADDI: entry = ST_ADDI;
      OP_ORI:  entry = ST_ORI;
      OP_LUI:  entry = ST_LUI;
      OP_LW:   entry = ST_LW;
      OP_SW:   entry = ST_SW;
      OP_BEQ:  entry = ST_BEQ;
      OP_BNE:  entry = ST_BNE;
      OP_J:    entry = ST_J;
      OP_JAL:  entry = ST_JAL;
      default: entry = ST_FETCH;
    endcase
  end

  assign enc_state = STATE_W'(entry);

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: selects the next microstore address every cycle.
// Latency: one cycle from control word / conditions to current_state.
// Backpressure: none; MOC waits stall in place and abort to state 0 after WAIT_LIMIT cycles.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int STATE_W    = 7,
  parameter int WAIT_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ir,
  input  logic [2:0]         n_field,
  input  logic [STATE_W-1:0] cr_field,
  input  logic               inv,
  input  logic [1:0]         cond_sel,
  input  logic               moc,
  input  logic               alu_zero,
  input  logic               cond_met,
  output logic [STATE_W-1:0] current_state,
  output logic               mem_timeout
);

  localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

  ctrl_t              ctrl;
  logic               cond_raw;
  logic               cond;
  logic               waiting;
  logic               limit_hit;
  logic [STATE_W-1:0] enc_state;
  logic [STATE_W-1:0] state_inc;
  logic [STATE_W-1:0] next_state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_nxt;

  assign ctrl = '{mode: n_mode_e'(n_field), inv: inv, sel: cond_sel_e'(cond_sel)};

  instr_encoder #(.STATE_W(STATE_W)) u_encoder (
    .ir        (ir),
    .enc_state (enc_state)
  );

  always_comb begin
    cond_raw = 1'b0;
    case (ctrl.sel)
      COND_MOC:   cond_raw = moc;
      COND_ZERO:  cond_raw = alu_zero;
      COND_MET:   cond_raw = cond_met;
      COND_FALSE: cond_raw = 1'b0;
      default:    cond_raw = 1'b0;
    endcase
  end

  assign cond      = cond_raw ^ ctrl.inv;
  assign state_inc = current_state + STATE_W'(1);

  // The limit is reached on the WAIT_LIMIT-th consecutive waiting cycle; cond arriving then still wins.
  assign waiting   = (ctrl.mode == N_WAIT) && !cond;
  assign limit_hit = waiting && (wait_cnt == LAST_WAIT);

  always_comb begin
    next_state = current_state;
    case (ctrl.mode)
      N_ENCODE: next_state = enc_state;
      N_JUMP:   next_state = cr_field;
      N_INC:    next_state = state_inc;
      N_BR_INC: next_state = cond ? cr_field : state_inc;
      N_BR_ENC: next_state = cond ? cr_field : enc_state;
      N_WAIT: begin
        if (cond)
          next_state = state_inc;
        else if (limit_hit)
          next_state = '0;
        else
          next_state = current_state;
      end
      N_HOLD:   next_state = current_state;
      N_ZERO:   next_state = '0;
      default:  next_state = '0;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = '0;
    if (waiting && !limit_hit)
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_state <= '0;
      wait_cnt      <= '0;
      mem_timeout   <= 1'b0;
    end else begin
      current_state <= next_state;
      wait_cnt      <= wait_cnt_nxt;
      mem_timeout   <= limit_hit;
    end
  end

  always @(posedge clk) begin
    if (!reset)
      assert (!$isunknown(n_field));
  end

endmodule
